// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

    // Sequencer states; the encoding is exported on the debug state port.
    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    // Default cycle counts for a 27 MHz reference clock.
    localparam int DEF_PLL_RST_CYCLES = 27;      // 1 us
    localparam int DEF_LOCK_TIMEOUT   = 270000;  // 10 ms
    localparam int DEF_STABLE_CYCLES  = 2700;    // 100 us

    // Timer width: enough bits for the largest terminal count, plus one spare.
    function automatic int timer_width(input int rst_cycles,
                                       input int timeout_cycles,
                                       input int stable_cycles);
        int m;
        m = rst_cycles;
        if (timeout_cycles > m) m = timeout_cycles;
        if (stable_cycles > m)  m = stable_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, async active-high reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; only q is safe to use in the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL reset, qualifies lock and releases system reset.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int TMR_W = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             lock_s;
    pll_state_t       cur_state;
    pll_state_t       next_state;
    logic [TMR_W-1:0] timer;
    logic             retry_inc;
    logic             loss_inc;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (lock),
        .q   (lock_s)
    );

    assign state = cur_state;

    // Next-state decode; lock_s takes priority over the timeout in WAIT_LOCK.
    always_comb begin
        next_state = cur_state;
        retry_inc  = 1'b0;
        loss_inc   = 1'b0;
        case (cur_state)
            RESET_PLL: begin
                if (timer == RST_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = STABLE;
                end else if (timer == TO_LAST) begin
                    next_state = RESET_PLL;
                    retry_inc  = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s)                next_state = WAIT_LOCK;
                else if (timer == STB_LAST) next_state = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    next_state = RESET_PLL;
                    loss_inc   = 1'b1;
                end
            end
            default: next_state = RESET_PLL;
        endcase
    end

    // State, timer and outputs all register on the same edge from next_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= RESET_PLL;
            timer     <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
        end else begin
            cur_state <= next_state;
            // Timer restarts from 0 on every state entry; it may wrap harmlessly in RUN.
            if (next_state != cur_state) timer <= '0;
            else                         timer <= timer + TMR_W'(1);
            pll_rst   <= (next_state == RESET_PLL);
            sys_rst   <= (next_state != RUN);
            ready     <= (next_state == RUN);
        end
    end

    // Debug counters saturate and are cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            if (retry_inc && retry_cnt != CNT_MAX) retry_cnt <= retry_cnt + CNT_W'(1);
            if (loss_inc && loss_cnt != CNT_MAX)   loss_cnt  <= loss_cnt + CNT_W'(1);
        end
    end

endmodule
